// File: rtl/seq_checker_0356_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_checker_0356_if
//  Description : Bundles the sample/status signals between the 0-3-5-6 counter
//                monitor and its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_checker_0356_if #(
    parameter int ECW = 8,
    parameter int WCW = 8
);
    logic           en;
    logic [3:0]     q;
    logic           locked;
    logic           err;
    logic [ECW-1:0] err_count;
    logic [WCW-1:0] wrap_count;
    logic [3:0]     expected;

    // Environment side: presents samples, observes status
    modport master (
        output en,
        output q,
        input  locked,
        input  err,
        input  err_count,
        input  wrap_count,
        input  expected
    );

    // Checker side: consumes samples, produces status
    modport slave (
        input  en,
        input  q,
        output locked,
        output err,
        output err_count,
        output wrap_count,
        output expected
    );
endinterface
`default_nettype wire

// File: rtl/seq_checker_0356.sv
`default_nettype none
// ============================================================================
//  Module      : seq_checker_0356
//  Description : Monitors a 0->3->5->6->0 counter, locks after LOCK_N correct
//                consecutive samples, then pulses err on any deviation and
//                keeps saturating error / wrap counters.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_checker_0356 #(
    parameter int LOCK_N = 4,
    parameter int ECW    = 8,
    parameter int WCW    = 8
) (
    input  wire logic            clk,
    input  wire logic            clear_n,
    seq_checker_0356_if.slave    bus
);

    localparam int c_GCW = $clog2(LOCK_N + 1);

    localparam logic [1:0] c_SEARCH  = 2'd0;
    localparam logic [1:0] c_ACQUIRE = 2'd1;
    localparam logic [1:0] c_LOCKED  = 2'd2;

    localparam logic [c_GCW-1:0] c_GC_ZERO = '0;
    localparam logic [c_GCW-1:0] c_GC_ONE  = c_GCW'(1);
    localparam logic [c_GCW-1:0] c_GC_LOCK = c_GCW'(LOCK_N);

    localparam logic [ECW-1:0] c_EC_ONE = ECW'(1);
    localparam logic [WCW-1:0] c_WC_ONE = WCW'(1);

    logic [1:0]       state_q,      state_d;
    logic [c_GCW-1:0] good_cnt_q,   good_cnt_d;
    logic [3:0]       expected_q,   expected_d;
    logic             err_q,        err_d;
    logic [ECW-1:0]   err_count_q,  err_count_d;
    logic [WCW-1:0]   wrap_count_q, wrap_count_d;

    logic             w_legal;
    logic [3:0]       w_nxt;
    logic             w_match;
    logic [c_GCW-1:0] w_good_inc;

    // Successor of the sampled value and whether that value is part of the cycle
    always_comb begin
        w_legal = 1'b1;
        w_nxt   = 4'd0;
        case (bus.q)
            4'd0:    w_nxt = 4'd3;
            4'd3:    w_nxt = 4'd5;
            4'd5:    w_nxt = 4'd6;
            4'd6:    w_nxt = 4'd0;
            default: begin
                w_legal = 1'b0;
                w_nxt   = 4'd0;
            end
        endcase
    end

    assign w_match    = (bus.q == expected_q);
    assign w_good_inc = good_cnt_q + c_GC_ONE;

    // State register: all status is registered so no input reaches an output combinationally
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= c_SEARCH;
            good_cnt_q   <= c_GC_ZERO;
            expected_q   <= 4'd0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            expected_q   <= expected_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    // Next-state: evaluate the sample only when enabled; err defaults low so it is a single-cycle pulse
    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        expected_d   = expected_q;
        err_d        = 1'b0;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;

        if (bus.en) begin
            case (state_q)
                c_SEARCH: begin
                    // Illegal samples leave the prediction untouched
                    if (w_legal) begin
                        expected_d = w_nxt;
                        good_cnt_d = c_GC_ONE;
                        state_d    = c_ACQUIRE;
                    end
                end

                c_ACQUIRE: begin
                    if (w_match) begin
                        good_cnt_d = w_good_inc;
                        expected_d = w_nxt;
                        if (w_good_inc == c_GC_LOCK) begin
                            state_d = c_LOCKED;
                        end
                    end else if (w_legal) begin
                        // A legal but unexpected value restarts the run from itself
                        expected_d = w_nxt;
                        good_cnt_d = c_GC_ONE;
                    end else begin
                        good_cnt_d = c_GC_ZERO;
                        state_d    = c_SEARCH;
                    end
                end

                c_LOCKED: begin
                    if (w_match) begin
                        expected_d = w_nxt;
                        if ((bus.q == 4'd6) && !(&wrap_count_q)) begin
                            wrap_count_d = wrap_count_q + c_WC_ONE;
                        end
                    end else begin
                        // The offending sample is discarded, not used as a new seed
                        err_d      = 1'b1;
                        good_cnt_d = c_GC_ZERO;
                        state_d    = c_SEARCH;
                        if (!(&err_count_q)) begin
                            err_count_d = err_count_q + c_EC_ONE;
                        end
                    end
                end

                default: begin
                    good_cnt_d = c_GC_ZERO;
                    state_d    = c_SEARCH;
                end
            endcase
        end
    end

    // Outputs: straight decode of the registered state
    always_comb begin
        bus.locked     = (state_q == c_LOCKED);
        bus.err        = err_q;
        bus.err_count  = err_count_q;
        bus.wrap_count = wrap_count_q;
        bus.expected   = expected_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_checker_0356.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_checker_0356
//  Description : Scoreboard bench for seq_checker_0356 with a reference model
//                of the locking/prediction rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_checker_0356;

    localparam int LOCK_N = 4;
    localparam int ECW    = 2;
    localparam int WCW    = 4;
    localparam int EC_MAX = (1 << ECW) - 1;
    localparam int WC_MAX = (1 << WCW) - 1;

    logic clk;
    logic clear_n;

    seq_checker_0356_if #(.ECW(ECW), .WCW(WCW)) bus ();

    seq_checker_0356 #(.LOCK_N(LOCK_N), .ECW(ECW), .WCW(WCW)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int locked;
        int err;
        int ec;
        int wc;
        int ex;
    } exp_t;

    exp_t sb[$];

    // Reference model: mode 0 = searching, 1 = acquiring, 2 = locked
    int cyc[4] = '{0, 3, 5, 6};
    int m_mode, m_run, m_exp, m_err, m_ec, m_wc;

    function automatic int succ(input int v);
        for (int i = 0; i < 4; i++)
            if (cyc[i] == v) return cyc[(i + 1) % 4];
        return -1;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_run = 0; m_exp = 0; m_err = 0; m_ec = 0; m_wc = 0;
    endfunction

    function automatic void model_step(input bit e, input int v);
        m_err = 0;
        if (!clear_n) begin
            model_reset();
            return;
        end
        if (!e) return;
        if (m_mode == 0) begin
            if (succ(v) >= 0) begin
                m_exp = succ(v); m_run = 1; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (v == m_exp) begin
                m_run++; m_exp = succ(v);
                if (m_run == LOCK_N) m_mode = 2;
            end else if (succ(v) >= 0) begin
                m_exp = succ(v); m_run = 1;
            end else begin
                m_mode = 0; m_run = 0;
            end
        end else begin
            if (v == m_exp) begin
                m_exp = succ(v);
                if (v == 6 && m_wc < WC_MAX) m_wc++;
            end else begin
                m_err = 1; m_mode = 0; m_run = 0;
                if (m_ec < EC_MAX) m_ec++;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Present one sample; the model's post-edge view goes to the scoreboard
    task automatic drive(input bit e, input int v);
        exp_t x;
        @(negedge clk);
        bus.en = e;
        bus.q  = 4'(v);
        model_step(e, v);
        x.locked = (m_mode == 2) ? 1 : 0;
        x.err = m_err; x.ec = m_ec; x.wc = m_wc; x.ex = m_exp;
        sb.push_back(x);
    endtask

    // Asynchronous reset mid-cycle, held over two edges, then released
    task automatic do_reset();
        @(negedge clk);
        #2 clear_n = 1'b0;
        #1;
        chk("async_rst_locked",  32'(bus.locked),     0);
        chk("async_rst_err",     32'(bus.err),        0);
        chk("async_rst_errcnt",  32'(bus.err_count),  0);
        chk("async_rst_wrapcnt", 32'(bus.wrap_count), 0);
        chk("async_rst_expect",  32'(bus.expected),   0);
        model_reset();
        drive(1'b1, 0);
        drive(1'b1, 3);
        @(negedge clk);
        bus.en  = 1'b0;
        clear_n = 1'b1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one registered result per sampled edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_locked",     32'(bus.locked),     32'(e.locked));
                chk("sb_err",        32'(bus.err),        32'(e.err));
                chk("sb_err_count",  32'(bus.err_count),  32'(e.ec));
                chk("sb_wrap_count", 32'(bus.wrap_count), 32'(e.wc));
                chk("sb_expected",   32'(bus.expected),   32'(e.ex));
            end
        end
    end

    initial begin
        int clean[8] = '{0, 3, 5, 6, 0, 3, 5, 6};
        int relock[4] = '{5, 6, 0, 3};
        int reseed[5] = '{3, 0, 3, 5, 6};
        int v;
        bit e;

        clear_n = 1'b0;
        bus.en  = 1'b0;
        bus.q   = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_locked",   32'(bus.locked),   0);
        chk("rst_expected", 32'(bus.expected), 0);
        @(negedge clk);
        clear_n = 1'b1;

        // Clean lock
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, clean[i]);
            if (i == 3) begin
                after_edge();
                chk("lock_on_4th", 32'(bus.locked), 1);
            end
        end
        after_edge();
        chk("wrap_after_8th", 32'(bus.wrap_count), 1);

        // Locked fault with expected=5
        drive(1'b1, 0);
        drive(1'b1, 3);
        after_edge();
        chk("expect_5", 32'(bus.expected), 5);
        drive(1'b1, 4);
        after_edge();
        chk("fault_err",    32'(bus.err),       1);
        chk("fault_errcnt", 32'(bus.err_count), 1);
        chk("fault_unlock", 32'(bus.locked),    0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, relock[i]);
            after_edge();
            chk("relock_no_err", 32'(bus.err), 0);
        end
        chk("relock_4th", 32'(bus.locked), 1);

        // Enable hold with expected=6
        drive(1'b1, 5);
        for (int i = 0; i < 5; i++) drive(1'b0, int'($urandom_range(0, 15)));
        after_edge();
        chk("hold_expected", 32'(bus.expected), 6);
        chk("hold_locked",   32'(bus.locked),   1);
        drive(1'b1, 6);
        after_edge();
        chk("hold_wrap", 32'(bus.wrap_count), 2);

        // Asynchronous reset while locked
        do_reset();

        // Acquire reseed
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, reseed[i]);
            if (i == 1) begin
                after_edge();
                chk("reseed_expect", 32'(bus.expected), 3);
            end
        end
        after_edge();
        chk("reseed_locked", 32'(bus.locked), 1);

        // Error counter saturation
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) drive(1'b1, cyc[i]);
            drive(1'b1, 1);
            after_edge();
            chk("sat_err_pulse", 32'(bus.err), 1);
        end
        chk("sat_errcnt", 32'(bus.err_count), 3);

        // Randomized traffic: mostly the true sequence, occasional corruption
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                e = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 11) == 0)
                    v = int'($urandom_range(0, 15));
                else if (m_mode == 0)
                    v = cyc[$urandom_range(0, 3)];
                else
                    v = m_exp;
                drive(e, v);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_checker_0356.md
# seq_checker_0356

Downstream monitor for the synchronous 0→3→5→6→0 counter. It samples the counter's 4-bit state every enabled clock and locks onto the sequence after a run of correct transitions. Once locked, it flags any deviation with a one-cycle error pulse and counts errors and completed sequence wraps. It sits directly on the counter outputs and feeds status to the test/debug logic.

## Interface
Parameters:
- LOCK_N, 4, number of consecutive correct samples needed to assert `locked` (legal range ≥2).
- ECW, 8, width of `err_count`.
- WCW, 8, width of `wrap_count`.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- clear_n  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; when low, all state and outputs hold.
- q  input  4  counter state sampled each enabled cycle, as {q3,q2,q1,q0}.
- locked  output  1  high while the FSM is in LOCKED.
- err  output  1  one-cycle pulse on a mismatch while locked.
- err_count  output  ECW  saturating count of mismatches detected while locked.
- wrap_count  output  WCW  saturating count of correct 6→0 predictions made while locked.
- expected  output  4  predicted value of the next sample.

## Operation
- Successor function: nxt(0)=3, nxt(3)=5, nxt(5)=6, nxt(6)=0.
- Legal values are {0,3,5,6}; every other value is illegal.
- Internal `good_cnt` is wide enough to hold LOCK_N.
- States: SEARCH (reset state), ACQUIRE, LOCKED.
- The sample is evaluated only when en=1. With en=0, nothing changes and err is 0.
- SEARCH:
  - Legal q: expected←nxt(q), good_cnt←1, go to ACQUIRE.
  - Illegal q: stay in SEARCH; expected is unchanged.
- ACQUIRE:
  - q==expected: good_cnt←good_cnt+1 and expected←nxt(q).
  - If good_cnt+1==LOCK_N on that match, go to LOCKED.
  - q!=expected and q legal: reseed with expected←nxt(q), good_cnt←1, stay in ACQUIRE.
  - q!=expected and q illegal: go to SEARCH, good_cnt←0.
  - err never fires in ACQUIRE.
- LOCKED:
  - q==expected: expected←nxt(q).
  - If q==6 on that match, wrap_count←wrap_count+1 (saturates at all-ones).
  - q!=expected: err←1 for exactly one cycle, err_count←err_count+1 (saturates), go to SEARCH, good_cnt←0, expected unchanged.
  - The mismatching sample is not reused for reseeding.
- Counters are never cleared except by reset.
- Async reset (clear_n=0), including mid-operation:
  - Immediately: state=SEARCH, locked=0, err=0, err_count=0, wrap_count=0, expected=0, good_cnt=0.
  - Held while clear_n=0.
  - The first sample is evaluated at the first rising clk edge after deassertion.

## Timing
- All outputs are registered. There is no combinational path from q or en to any output.
- err, locked, counters and expected update on the same rising edge that samples the triggering q.
- err is therefore high during the cycle after the offending q was presented.
- Lock latency from SEARCH with a clean sequence: locked rises on the LOCK_N-th consecutive enabled edge, counting the seeding sample as the first.
- locked falls on the same edge that raises err.
- Back-to-back mismatches: after an error the FSM is in SEARCH, so the next bad sample produces no err.
- Saturation: a counter at all-ones stays at all-ones. err still pulses when err_count is saturated.
- en low for any number of cycles inserts no error; the sequence resumes from the held expected value.

## Test plan
- Reset: drive clear_n=0 mid-lock, with no clk edge in between. Required: locked=0, err=0, counts=0, expected=0 asynchronously.
- Clean lock, LOCK_N=4: feed 0,3,5,6,0,3,5,6. Required:
  - locked=1 after the 4th edge (the sample 6).
  - wrap_count=1 after the 8th edge (the second 6).
  - err stays 0 throughout.
- Locked fault: once locked with expected=5, feed 4. Required:
  - err=1 for one cycle, err_count=1, locked=0.
  - Then feed 5,6,0,3: relocks on the 4th edge with no err.
- Acquire reseed: from reset, feed 3,0,3,5,6. Required:
  - The 0 reseeds (expected=3).
  - locked=1 after the sample 6, with err always 0.
- Enable hold: while locked with expected=6, drop en for 5 cycles while q toggles randomly. Required: no err and no state change. Then raise en with q=6: wrap_count increments.
- Saturation, ECW=2: force 4 locked faults. Required: err_count=3 and err pulses every time.
